// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-256 constants, FSM states, inverse S-box and GF(2^8) helpers
package aes_pkg;

  localparam int NUM_ROUNDS  = 14;
  localparam int BLOCK_W     = 128;
  localparam int KEY_CHAIN_W = BLOCK_W * (NUM_ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  // Element 0 sits in the most significant byte of the concatenation.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Round key k lives at [KEY_CHAIN_W-1-128k -: 128]; shifting keeps the select constant.
  function automatic logic [BLOCK_W-1:0] rk(input logic [KEY_CHAIN_W-1:0] chain,
                                            input logic [3:0] k);
    logic [KEY_CHAIN_W-1:0] sh;
    sh = chain << (BLOCK_W * k);
    return sh[KEY_CHAIN_W-1 -: BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational inverse round; final round skips InvMixColumns
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state_i,
  input  logic [BLOCK_W-1:0] key_i,
  input  logic               final_round_i,
  output logic [BLOCK_W-1:0] next_state_o
);

  logic [BLOCK_W-1:0] shifted;
  logic [BLOCK_W-1:0] subbed;
  logic [BLOCK_W-1:0] keyed;
  logic [BLOCK_W-1:0] mixed;

  inv_shift_rows u_shift (.in_i(state_i), .out_o(shifted));
  inv_sub_bytes  u_sub   (.in_i(shifted), .out_o(subbed));

  assign keyed = subbed ^ key_i;

  inv_mix_columns u_mix (.in_i(keyed), .out_o(mixed));

  assign next_state_o = final_round_i ? keyed : mixed;

endmodule

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - AES InvMixColumns over GF(2^8) mod 0x11B
module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] in_i,
  output logic [BLOCK_W-1:0] out_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = in_i[BLOCK_W-1-32*c -: 8];
    assign a1 = in_i[BLOCK_W-9-32*c -: 8];
    assign a2 = in_i[BLOCK_W-17-32*c -: 8];
    assign a3 = in_i[BLOCK_W-25-32*c -: 8];

    assign out_o[BLOCK_W-1-32*c -: 8]  = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
    assign out_o[BLOCK_W-9-32*c -: 8]  = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
    assign out_o[BLOCK_W-17-32*c -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
    assign out_o[BLOCK_W-25-32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
  end

endmodule

// File: rtl/inv_shift_rows.sv
// rtl/inv_shift_rows.sv - AES InvShiftRows: row r rotates right by r columns
module inv_shift_rows
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] in_i,
  output logic [BLOCK_W-1:0] out_o
);

  // Byte 4c+r is row r, column c.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign out_o[BLOCK_W-1-8*(4*c+r) -: 8] = in_i[BLOCK_W-1-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// rtl/inv_sub_bytes.sv - AES InvSubBytes: 16 parallel inverse S-box lanes
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] in_i,
  output logic [BLOCK_W-1:0] out_o
);

  for (genvar i = 0; i < 16; i++) begin : g_lane
    assign out_o[BLOCK_W-1-8*i -: 8] = INV_SBOX[in_i[BLOCK_W-1-8*i -: 8]];
  end

endmodule

// File: rtl/aes_decryption_iter.sv
// rtl/aes_decryption_iter.sv - iterative AES-256 decryptor, one inverse round per clock
module aes_decryption_iter
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS_P      = NUM_ROUNDS,
  parameter int KEY_CHAIN_WIDTH_P = 128 * (NUM_ROUNDS_P + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [BLOCK_W-1:0]           ciphertext_i,
  input  logic [KEY_CHAIN_WIDTH_P-1:0] key_chain_i,
  output logic                         v_o,
  input  logic                         yumi_i,
  output logic [BLOCK_W-1:0]           plaintext_o
);

  state_e             state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] round_out;

  // Key chain is used live, so the driver holds it stable while busy.
  assign round_key = rk(key_chain_i, round_q);

  aes_inv_round u_round (
    .state_i       (blk_q),
    .key_i         (round_key),
    .final_round_i (round_q == 4'd0),
    .next_state_o  (round_out)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      round_q <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;
    ready_o = 1'b0;
    v_o     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          blk_d   = ciphertext_i ^ rk(key_chain_i, 4'(NUM_ROUNDS_P));
          round_d = 4'(NUM_ROUNDS_P - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = round_out;
        if (round_q == 4'd0) begin
          state_d = DONE;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign plaintext_o = blk_q;

endmodule

// File: tb/tb_aes_decryption_iter.sv
// tb/tb_aes_decryption_iter.sv - scoreboard bench with an AES-256 forward-cipher reference
module tb_aes_decryption_iter;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

  logic           clk_i;
  logic           reset_i;
  logic           v_i;
  logic           ready_o;
  logic [127:0]   ciphertext_i;
  logic [1919:0]  key_chain_i;
  logic           v_o;
  logic           yumi_i;
  logic [127:0]   plaintext_o;

  aes_decryption_iter dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .ciphertext_i (ciphertext_i),
    .key_chain_i  (key_chain_i),
    .v_o          (v_o),
    .yumi_i       (yumi_i),
    .plaintext_o  (plaintext_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0] pt;
    time          t_acc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ch;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) ch[1919-32*i -: 32] = w[i];
    return ch;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ch);
    logic [7:0]   st  [4][4];
    logic [7:0]   tmp [4][4];
    logic [7:0]   a   [4];
    logic [127:0] ct;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ ch[1919-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = sbox[st[r][(c+r)%4]];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = tmp[r][c];
          tmp[0][c] = gm(a[0], 8'h02) ^ gm(a[1], 8'h03) ^ a[2] ^ a[3];
          tmp[1][c] = a[0] ^ gm(a[1], 8'h02) ^ gm(a[2], 8'h03) ^ a[3];
          tmp[2][c] = a[0] ^ a[1] ^ gm(a[2], 8'h02) ^ gm(a[3], 8'h03);
          tmp[3][c] = gm(a[0], 8'h03) ^ a[1] ^ a[2] ^ gm(a[3], 8'h02);
        end
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          st[r][c] = tmp[r][c] ^ ch[1919-128*rnd-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127-8*(4*c+r) -: 8] = st[r][c];
    return ct;
  endfunction

  // Present a block, push its expectation at the accept edge, return once v_o has been seen.
  task automatic send(input logic [127:0] ct, input logic [1919:0] ch, input logic [127:0] pt);
    int n;
    exp_t e;
    ciphertext_i = ct;
    key_chain_i  = ch;
    v_i          = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 128'(n), 128'd0);
        return;
      end
    end
    @(posedge clk_i);
    e.pt = pt;
    e.t_acc = $time;
    sb_q.push_back(e);
    #1;
    n = 0;
    while (1) begin
      @(negedge clk_i);
      if (v_o) break;
      chk("busy_ready", 128'(ready_o), 128'd0);
      n++;
      if (n > 40) begin
        chk("result_timeout", 128'(n), 128'd0);
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  logic         prev_v = 1'b0;
  logic [127:0] prev_pt = '0;
  logic         idle_due = 1'b0;

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_v   = 1'b0;
      idle_due = 1'b0;
    end else begin
      if (idle_due) begin
        chk("idle_after_yumi", {126'd0, ready_o, v_o}, {126'd0, 1'b1, 1'b0});
        idle_due = 1'b0;
      end
      if (v_o) begin
        if (!prev_v) begin
          chk("done_ready", 128'(ready_o), 128'd0);
          if (sb_q.size() == 0)
            chk("unexpected_output", plaintext_o, 128'hx);
          else
            chk("latency", 128'(($time - sb_q[0].t_acc - 5) / 10), 128'd14);
        end else begin
          chk("hold_plaintext", plaintext_o, prev_pt);
        end
        if (yumi_i && sb_q.size() != 0) begin
          chk("plaintext", plaintext_o, sb_q[0].pt);
          void'(sb_q.pop_front());
          idle_due = 1'b1;
        end
      end
      prev_v  = v_o;
      prev_pt = plaintext_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1919:0] ch_c3, ch_z, ch;
    logic [255:0]  key;
    logic [127:0]  pt;
    int            n;

    build_sbox();
    ch_c3 = expand(KEY_C3);
    ch_z  = expand(256'd0);

    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b1;
    ciphertext_i = '0; key_chain_i = '0;
    #1;
    chk("reset_ready", 128'(ready_o), 128'd1);
    chk("reset_v", 128'(v_o), 128'd0);
    chk("reset_plaintext", plaintext_o, 128'd0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    send(CT_C3, ch_c3, PT_C3);
    v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    send(CT_Z, ch_z, 128'd0);
    v_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Output stall with stray v_i pulses that must be ignored.
    yumi_i = 1'b0;
    send(CT_C3, ch_c3, PT_C3);
    for (int i = 0; i < 10; i++) begin
      v_i = 1'($urandom_range(0, 1));
      ciphertext_i = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk_i);
      chk("stall_ready", 128'(ready_o), 128'd0);
      chk("stall_v", 128'(v_o), 128'd1);
      @(posedge clk_i);
      #1;
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;

    // Back-to-back with v_i held high.
    send(CT_C3, ch_c3, PT_C3);
    send(CT_Z, ch_z, 128'd0);
    v_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // Reset aborts an operation mid-round.
    ciphertext_i = CT_C3;
    key_chain_i  = ch_c3;
    v_i          = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!ready_o && n < 200);
    @(posedge clk_i);
    #1 v_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    chk("midreset_v", 128'(v_o), 128'd0);
    chk("midreset_ready", 128'(ready_o), 128'd1);
    chk("midreset_plaintext", plaintext_o, 128'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("postreset_v", 128'(v_o), 128'd0);
    @(posedge clk_i);
    #1;
    send(CT_C3, ch_c3, PT_C3);
    v_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Loopback: random plaintext/key encrypted by the reference, decrypted by the DUT.
    for (int i = 0; i < 1000; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ch  = expand(key);
      yumi_i = 1'($urandom_range(0, 1));
      send(encrypt(pt, ch), ch, pt);
      v_i = 1'b0;
      if (!yumi_i) begin
        repeat ($urandom_range(0, 3)) @(posedge clk_i);
        #1 yumi_i = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    repeat (2) @(posedge clk_i);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
